// File: rtl/demultiplexer_reg_pkg.sv
// Shared constants and types for the registered 1-to-2 demultiplexer.
// Optional transfer counters are enabled by DEMUX_STATS_EN.
package demultiplexer_reg_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEFAULT_N  = 8;
    localparam int DEFAULT_CW = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demultiplexer_reg_if.sv
// Producer-side and two consumer-side valid/ready handshakes of the demultiplexer.
interface demultiplexer_reg_if #(
    parameter int N = 8
);
    logic [N-1:0] in;
    logic         Sel;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_a;
    logic         out_a_valid;
    logic         out_a_ready;
    logic [N-1:0] out_b;
    logic         out_b_valid;
    logic         out_b_ready;

    modport master (
        output in, Sel, in_valid, out_a_ready, out_b_ready,
        input  in_ready, out_a, out_a_valid, out_b, out_b_valid
    );

    modport slave (
        input  in, Sel, in_valid, out_a_ready, out_b_ready,
        output in_ready, out_a, out_a_valid, out_b, out_b_valid
    );
endinterface

// File: rtl/demultiplexer_reg_slot.sv
// One-entry valid/ready holding register; free means a load may be taken this cycle.
module demux_slot
    import demultiplexer_reg_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic         free
);
    slot_state_t  r_state;
    logic [N-1:0] r_data;

    // Data is only ever overwritten by a load, so a drained slot keeps its last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else if (load) begin
            r_state <= SLOT_FULL;
            r_data  <= din;
        end else if (r_state == SLOT_FULL && ready) begin
            r_state <= SLOT_EMPTY;
        end
    end

    assign dout  = r_data;
    assign valid = (r_state == SLOT_FULL);
    assign free  = (r_state == SLOT_EMPTY) || ready;
endmodule

// File: rtl/demultiplexer_reg.sv
// Registered 1-to-2 demultiplexer steering one word per cycle to channel a or b.
// Define DEMUX_STATS_EN to add per-channel accepted-word counters cnt_a/cnt_b.
module demultiplexer_reg
    import demultiplexer_reg_pkg::*;
#(
    parameter int N  = DEFAULT_N
`ifdef DEMUX_STATS_EN
   ,parameter int CW = DEFAULT_CW
`endif
) (
    input  logic                clk,
    input  logic                rst,
    demultiplexer_reg_if.slave  bus
`ifdef DEMUX_STATS_EN
   ,output logic [CW-1:0]       cnt_a,
    output logic [CW-1:0]       cnt_b
`endif
);
    logic w_free_a;
    logic w_free_b;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;

    assign bus.in_ready = (bus.Sel == SEL_B) ? w_free_b : w_free_a;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_load_a     = w_accept && (bus.Sel == SEL_A);
    assign w_load_b     = w_accept && (bus.Sel == SEL_B);

    demux_slot #(.N(N)) u_slot_a (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load_a),
        .din   (bus.in),
        .dout  (bus.out_a),
        .valid (bus.out_a_valid),
        .ready (bus.out_a_ready),
        .free  (w_free_a)
    );

    demux_slot #(.N(N)) u_slot_b (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load_b),
        .din   (bus.in),
        .dout  (bus.out_b),
        .valid (bus.out_b_valid),
        .ready (bus.out_b_ready),
        .free  (w_free_b)
    );

`ifdef DEMUX_STATS_EN
    logic [CW-1:0] r_cnt_a;
    logic [CW-1:0] r_cnt_b;

    // Counters wrap naturally at 2^CW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_load_a) r_cnt_a <= r_cnt_a + 1'b1;
            if (w_load_b) r_cnt_b <= r_cnt_b + 1'b1;
        end
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;
`endif
endmodule

// File: tb/tb_demultiplexer_reg.sv
// Directed bench for demultiplexer_reg with a per-channel scoreboard.
module tb_demultiplexer_reg;
    localparam int TB_N  = 8;
    localparam int TB_CW = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [TB_N-1:0] qa[$];
    logic [TB_N-1:0] qb[$];

    demultiplexer_reg_if #(.N(TB_N)) bus ();

`ifdef DEMUX_STATS_EN
    logic [TB_CW-1:0] cnt_a;
    logic [TB_CW-1:0] cnt_b;

    demultiplexer_reg #(.N(TB_N), .CW(TB_CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
    );
`else
    demultiplexer_reg #(.N(TB_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: retire outgoing words first, then record the word being accepted.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_a_valid && bus.out_a_ready) begin
                if (qa.size() == 0) chk("a_unexpected", {24'h0, bus.out_a}, 32'hFFFF_FFFF);
                else chk("a_data", {24'h0, bus.out_a}, {24'h0, qa.pop_front()});
            end
            if (bus.out_b_valid && bus.out_b_ready) begin
                if (qb.size() == 0) chk("b_unexpected", {24'h0, bus.out_b}, 32'hFFFF_FFFF);
                else chk("b_data", {24'h0, bus.out_b}, {24'h0, qb.pop_front()});
            end
            if (bus.in_valid && bus.in_ready) begin
                if (bus.Sel) qb.push_back(bus.in);
                else         qa.push_back(bus.in);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in = '0;
        bus.Sel = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_a_ready = 1'b0;
        bus.out_b_ready = 1'b0;
        step();
        step();
        chk("rst_a_valid", {31'h0, bus.out_a_valid}, 32'h0);
        chk("rst_b_valid", {31'h0, bus.out_b_valid}, 32'h0);
        chk("rst_a_data", {24'h0, bus.out_a}, 32'h0);
        chk("rst_b_data", {24'h0, bus.out_b}, 32'h0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

        // Basic routing
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        bus.in = 8'hA5; bus.Sel = 1'b0; bus.in_valid = 1'b1;
        #1 chk("basic_in_ready", {31'h0, bus.in_ready}, 32'h1);
        step();
        chk("basic_a_valid", {31'h0, bus.out_a_valid}, 32'h1);
        chk("basic_a_data", {24'h0, bus.out_a}, 32'hA5);
        bus.in = 8'h3C; bus.Sel = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("basic_b_valid", {31'h0, bus.out_b_valid}, 32'h1);
        chk("basic_b_data", {24'h0, bus.out_b}, 32'h3C);
        chk("basic_a_drop", {31'h0, bus.out_a_valid}, 32'h0);
        step();
        chk("basic_b_drop", {31'h0, bus.out_b_valid}, 32'h0);

        // Back-pressure isolation
        bus.out_b_ready = 1'b0;
        bus.in = 8'h11; bus.Sel = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.in = 8'h22;
        #1 chk("bp_b_blocked", {31'h0, bus.in_ready}, 32'h0);
        step();
        chk("bp_b_hold", {24'h0, bus.out_b}, 32'h11);
        chk("bp_b_valid", {31'h0, bus.out_b_valid}, 32'h1);
        chk("bp_b_still_blocked", {31'h0, bus.in_ready}, 32'h0);
        bus.in = 8'h33; bus.Sel = 1'b0;
        #1 chk("bp_a_open", {31'h0, bus.in_ready}, 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_a_data", {24'h0, bus.out_a}, 32'h33);
        chk("bp_b_hold2", {24'h0, bus.out_b}, 32'h11);
        bus.out_b_ready = 1'b1;
        step();
        chk("bp_b_drained", {31'h0, bus.out_b_valid}, 32'h0);

        // Throughput: alternating channels, one word per cycle
        for (int i = 0; i < 16; i++) begin
            bus.in = 8'(i);
            bus.Sel = i[0];
            bus.in_valid = 1'b1;
            #1 chk("tp_in_ready", {31'h0, bus.in_ready}, 32'h1);
            step();
            if (i[0]) chk("tp_b_latency", {24'h0, bus.out_b}, i);
            else      chk("tp_a_latency", {24'h0, bus.out_a}, i);
        end
        bus.in_valid = 1'b0;
        step();
        step();

        // Simultaneous drain and reload
        bus.in = 8'h44; bus.Sel = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in = 8'h55;
        #1 chk("sim_in_ready", {31'h0, bus.in_ready}, 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("sim_a_valid", {31'h0, bus.out_a_valid}, 32'h1);
        chk("sim_a_data", {24'h0, bus.out_a}, 32'h55);
        step();
        chk("sim_a_drop", {31'h0, bus.out_a_valid}, 32'h0);

        // Reset mid-stream with both slots full
        bus.out_a_ready = 1'b0;
        bus.out_b_ready = 1'b0;
        bus.in = 8'h66; bus.Sel = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in = 8'h77; bus.Sel = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("mid_a_full", {31'h0, bus.out_a_valid}, 32'h1);
        chk("mid_b_full", {31'h0, bus.out_b_valid}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_a_valid", {31'h0, bus.out_a_valid}, 32'h0);
        chk("mid_rst_b_valid", {31'h0, bus.out_b_valid}, 32'h0);
        chk("mid_rst_a_data", {24'h0, bus.out_a}, 32'h0);
        chk("mid_rst_b_data", {24'h0, bus.out_b}, 32'h0);
        qa.delete();
        qb.delete();
        step();
        rst = 1'b0;
        step();
        bus.Sel = 1'b0;
        #1 chk("post_rst_ready_a", {31'h0, bus.in_ready}, 32'h1);
        bus.Sel = 1'b1;
        #1 chk("post_rst_ready_b", {31'h0, bus.in_ready}, 32'h1);
`ifdef DEMUX_STATS_EN
        chk("cnt_a_reset", {28'h0, cnt_a}, 32'h0);
        chk("cnt_b_reset", {28'h0, cnt_b}, 32'h0);
`endif

        // Counter wrap: 17 accepts to a, 3 to b
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in = 8'(8'h80 + i);
            bus.Sel = (i >= 17);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
`ifdef DEMUX_STATS_EN
        chk("cnt_a_wrap", {28'h0, cnt_a}, 32'(17 % (1 << TB_CW)));
        chk("cnt_b", {28'h0, cnt_b}, 32'h3);
`endif
        chk("qa_empty", qa.size(), 32'h0);
        chk("qb_empty", qb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demultiplexer_reg.md
Name: demultiplexer_reg

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the 2:1 operand multiplexer. Routes one N-bit input word to output channel a or b under control of Sel.
- Each output channel has its own one-entry holding register with a valid/ready handshake, so the ALU result path can steer results to two consumers (e.g. register-file writeback and flag/status unit) that stall independently.
- Sits after the ALU output stage.

Parameters:
- N, 8, data width of input and both outputs.
- CW, 16, width of per-channel transfer counters; used only with DEMUX_STATS_EN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  N  input data word.
- Sel  input  1  route select, sampled with in: 0 = channel a, 1 = channel b.
- in_valid  input  1  producer has a word on in/Sel.
- in_ready  output  1  block accepts the word this cycle.
- out_a  output  N  channel a data.
- out_a_valid  output  1  channel a holds a word.
- out_a_ready  input  1  channel a consumer takes the word.
- out_b  output  N  channel b data.
- out_b_valid  output  1  channel b holds a word.
- out_b_ready  input  1  channel b consumer takes the word.
- cnt_a  output  CW  accepted-to-a count; present only with DEMUX_STATS_EN.
- cnt_b  output  CW  accepted-to-b count; present only with DEMUX_STATS_EN.

Behaviour:
- Reset (async, on rst high, held while high): out_a, out_b = 0; out_a_valid, out_b_valid = 0; counters = 0.
- Each channel slot has two states:
  - EMPTY: valid = 0.
  - FULL: valid = 1, data held stable.
- Selected-slot free condition: slot EMPTY, or slot FULL with its ready = 1 in the same cycle.
- in_ready is combinational:
  - Sel = 0: !out_a_valid | out_a_ready.
  - Sel = 1: !out_b_valid | out_b_ready.
  - Independent of in_valid.
- Accept = in_valid & in_ready. On accept, the selected slot loads in and becomes FULL at the next edge. The unselected slot is untouched.
- Latency: a word accepted at edge k is visible on out_x with out_x_valid = 1 after edge k, i.e. 1 cycle.
- Drain: slot FULL with ready = 1 and no reload → EMPTY next edge. Data register keeps its last value; it is not cleared.
- Simultaneous drain and reload of the same slot → stays FULL with the new data, giving full throughput of 1 word/cycle per channel.
- Channels are independent: a stalled b (out_b_ready = 0, FULL) blocks only Sel = 1 words. Sel = 0 words continue to flow.
- Sel or in may change freely while in_valid = 1 and in_ready = 0. There is no lock; the value present at the accepting edge is used.
- Data on out_x must not change while out_x_valid = 1 and out_x_ready = 0.
- in_valid = 0: no slot loads, whatever Sel is.
- Reset mid-operation: held words are discarded and both valids drop immediately (asynchronously).

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - cnt_a and cnt_b ports exist.
  - Each increments by 1 on every accept routed to its channel.
  - Counters wrap modulo 2^CW (all-ones + 1 → 0).
  - Reset to 0.
- Undefined: ports and counter logic are absent. Datapath and handshake behaviour are identical in both builds.

Decomposition:
- Shared package/include (alu_defs): constants SEL_A = 1'b0, SEL_B = 1'b1, and the default widths N and CW.
- Sub-module demux_slot (parameter N): one-entry valid/ready holding register, with ports clk, rst, load, din, dout, valid, ready, free. Instantiated twice.
- Top level computes load_a/load_b from Sel and accept, and muxes free_a/free_b onto in_ready.

Test Plan:
- Reset: assert rst mid-stream with both slots FULL → out_a_valid = out_b_valid = 0 and out_a = out_b = 0 immediately; in_ready = 1 after release.
- Basic routing: in = 8'hA5, Sel = 0, valid 1 cycle, out_a_ready = 1 → out_a = A5 with out_a_valid = 1 the next cycle. Then in = 8'h3C, Sel = 1 → out_b = 3C; out_a_valid drops.
- Back-pressure isolation: out_b_ready = 0, send 8'h11 to b, then 8'h22 to b → second word has in_ready = 0 and out_b holds 11. Meanwhile 8'h33 to a is accepted the same cycle.
- Throughput: both readies = 1, 16 consecutive words 0x00..0x0F alternating Sel → in_ready stays 1 every cycle; each channel sees its words in order, 1-cycle latency.
- Simultaneous drain/reload: slot a FULL with 8'h44 and out_a_ready = 1, while 8'h55 with Sel = 0 is accepted → out_a_valid stays 1 and out_a = 55 next cycle.
- With DEMUX_STATS_EN and CW = 4: 17 accepts to a, 3 to b → cnt_a = 1 (wrapped), cnt_b = 3.
